uart_echo_responder: RTL and testbench

Far-end responder for the Uart8 serial link. It consumes bytes completed by a Uart8 receiver, buffers them in a small FIFO, and retransmits each one, optionally XOR-transformed, through the same Uart8's transmitter handshake. It sits beside a Uart8 instance as the echo/loopback peer for a host-side initiator, and exposes error and overflow statistics.

---
 rtl/uart_echo_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_echo_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
//
// Echo peer for a Uart8 link. Bytes completed by the Uart8 receiver are
// buffered in a small circular FIFO. Each byte is then handed back to the
// Uart8 transmitter exactly once and in arrival order, XOR-transformed with
// XOR_MASK. Framing errors are counted, and bytes lost to a full FIFO raise
// a sticky overflow flag.
//
// Parameters
//   DEPTH         FIFO depth in bytes (power of two, >= 2)
//   XOR_MASK      mask applied to every echoed byte
//   START_TIMEOUT cycles txStart may wait for txBusy before it gives up (>= 1)
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   en               block enable
//   rxEn, txEn       registered copies of en, to the Uart8 enables
//   rxDone           Uart8 receive complete (level; its rising edge is the event)
//   rxErr, rxOut     framing error flag and received byte, valid with rxDone
//   txBusy           Uart8 transmitter busy; this is the handshake the FSM uses
//   txDone           Uart8 transmit complete (informational only)
//   txStart, txIn    transmit request and byte; txIn is stable while txStart=1
//   fifoCount        number of bytes currently buffered (0..DEPTH)
//   overflow         sticky, set when a byte was dropped on a full FIFO
//   errCount         number of framing errors, saturating at 255
// ---------------------------------------------------------------------------
module uart_echo_responder #(
  parameter int         DEPTH         = 4,
  parameter logic [7:0] XOR_MASK      = 8'h00,
  parameter int         START_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  output logic                     rxEn,
  output logic                     txEn,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic [7:0]               rxOut,
  input  logic                     txBusy,
  input  logic                     txDone,
  output logic                     txStart,
  output logic [7:0]               txIn,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     overflow,
  output logic [7:0]               errCount
);

  // Pointer, count and timeout-counter widths. The timeout counter only
  // needs to hold 0..START_TIMEOUT-1, because the abort happens on the
  // cycle the next count would reach START_TIMEOUT.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TO_ZERO  = TW'(0);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } stateT;

  // Saturating increment used for the framing-error statistic.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      satInc8 = value;
    end else begin
      satInc8 = value + 8'd1;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic          enR;
  logic          rxDonePrevR;
  logic [7:0]    fifoMemR [DEPTH];
  logic [PW-1:0] wrPtrR;
  logic [PW-1:0] rdPtrR;
  logic [CW-1:0] countR;
  logic          overflowR;
  logic [7:0]    errCountR;
  stateT         stateR;
  logic          txStartR;
  logic [7:0]    txInR;
  logic [TW-1:0] toCntR;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  logic          rxEventS;
  logic          fullS;
  logic          pushS;
  logic          popS;
  logic [7:0]    headS;
  stateT         stateNextS;
  logic          txStartNextS;
  logic [7:0]    txInNextS;
  logic [TW-1:0] toCntNextS;
  logic          unusedTxDoneS;

  // txDone is informational; completion is tracked through txBusy alone.
  assign unusedTxDoneS = txDone;

  // A receive event is a rising edge of rxDone while enabled. The edge
  // register keeps sampling even while disabled, so a level that was
  // already high when en returns does not count as a fresh byte.
  assign rxEventS = rxDone & ~rxDonePrevR & en;
  assign fullS    = (countR == CNT_FULL);
  assign headS    = fifoMemR[rdPtrR];

  // The head leaves the FIFO on the edge where a pending request sees the
  // transmitter go busy. A simultaneous pop frees the slot, so a push into
  // a full FIFO is still accepted in that cycle.
  assign popS  = (stateR == ST_START) & txBusy;
  assign pushS = rxEventS & ~rxErr & (~fullS | popS);

  // Enable mirror and rxDone edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      enR         <= 1'b0;
      rxDonePrevR <= 1'b0;
    end else begin
      enR         <= en;
      rxDonePrevR <= rxDone;
    end
  end

  // FIFO storage; no reset needed since a reset empties the FIFO via the
  // pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && pushS) begin
      fifoMemR[wrPtrR] <= rxOut;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrR <= {PW{1'b0}};
      rdPtrR <= {PW{1'b0}};
      countR <= CNT_ZERO;
    end else begin
      if (pushS) begin
        wrPtrR <= wrPtrR + PTR_ONE;
      end
      if (popS) begin
        rdPtrR <= rdPtrR + PTR_ONE;
      end
      case ({pushS, popS})
        2'b10:   countR <= countR + CNT_ONE;
        2'b01:   countR <= countR - CNT_ONE;
        default: countR <= countR;
      endcase
    end
  end

  // Link statistics: saturating framing-error count and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      errCountR <= 8'd0;
      overflowR <= 1'b0;
    end else begin
      if (rxEventS && rxErr) begin
        errCountR <= satInc8(errCountR);
      end
      if (rxEventS && !rxErr && fullS && !popS) begin
        overflowR <= 1'b1;
      end
    end
  end

  // Transmit FSM state register, together with the registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR   <= ST_IDLE;
      txStartR <= 1'b0;
      txInR    <= 8'd0;
      toCntR   <= TO_ZERO;
    end else begin
      stateR   <= stateNextS;
      txStartR <= txStartNextS;
      txInR    <= txInNextS;
      toCntR   <= toCntNextS;
    end
  end

  // Transmit FSM next-state logic. An accepted busy takes priority over a
  // disable or timeout in the same cycle, because by then the Uart8 has
  // already latched the byte.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      ST_IDLE: begin
        if (en && (countR != CNT_ZERO) && !txBusy) begin
          stateNextS = ST_START;
        end else begin
          stateNextS = ST_IDLE;
        end
      end
      ST_START: begin
        if (txBusy) begin
          stateNextS = ST_WAIT_DONE;
        end else if (!en || (toCntR == TO_LAST)) begin
          stateNextS = ST_IDLE;
        end else begin
          stateNextS = ST_START;
        end
      end
      ST_WAIT_DONE: begin
        // The in-flight frame always completes, so en is not checked here.
        if (!txBusy) begin
          stateNextS = ST_IDLE;
        end else begin
          stateNextS = ST_WAIT_DONE;
        end
      end
      default: begin
        stateNextS = ST_IDLE;
      end
    endcase
  end

  // Transmit FSM output logic: next values of the registered outputs.
  always_comb begin
    txStartNextS = 1'b0;
    txInNextS    = txInR;
    toCntNextS   = TO_ZERO;

    txStartNextS = (stateNextS == ST_START);

    // txIn is loaded only when a request begins, so it stays stable for
    // the whole request and also across a timeout retry.
    if ((stateR == ST_IDLE) && (stateNextS == ST_START)) begin
      txInNextS = headS ^ XOR_MASK;
    end else begin
      txInNextS = txInR;
    end

    // The wait counter runs only while a request is pending and restarts
    // from zero on every new request.
    if (stateR == ST_START) begin
      toCntNextS = toCntR + TO_ONE;
    end else begin
      toCntNextS = TO_ZERO;
    end
  end

  assign rxEn      = enR;
  assign txEn      = enR;
  assign txStart   = txStartR;
  assign txIn      = txInR;
  assign fifoCount = countR;
  assign overflow  = overflowR;
  assign errCount  = errCountR;

endmodule

// File: tb/tb_uart_echo_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_responder
//
// Scoreboard bench for uart_echo_responder (DEPTH=4, XOR_MASK=8'hFF,
// START_TIMEOUT=8). The driver runs a byte-level reference model: a FIFO
// occupancy count plus an expected-echo queue, sticky overflow and
// saturating error count. It also plays the Uart8 transmitter. A separate
// monitor pops the queue on every txStart/txBusy handshake and compares
// txIn. Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_uart_echo_responder;

  localparam int         DEPTH = 4;
  localparam logic [7:0] MASK  = 8'hFF;
  localparam int         TOUT  = 8;

  logic       clk = 1'b0;
  logic       reset, en, rxDone, rxErr, txBusy, txDone;
  logic [7:0] rxOut;
  logic       rxEn, txEn, txStart, overflow;
  logic [7:0] txIn, errCount;
  logic [2:0] fifoCount;

  always #5 clk = ~clk;

  uart_echo_responder #(
    .DEPTH(DEPTH), .XOR_MASK(MASK), .START_TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .rxEn(rxEn), .txEn(txEn),
    .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
    .txBusy(txBusy), .txDone(txDone), .txStart(txStart), .txIn(txIn),
    .fifoCount(fifoCount), .overflow(overflow), .errCount(errCount)
  );

  int nVec = 0;
  int nMis = 0;

  // Reference model state
  int         occ = 0;
  logic       ovM = 1'b0;
  int         errM = 0;
  logic       prevRxM = 1'b0;
  logic       enQM = 1'b0;
  logic [7:0] expQ[$];

  // Uart8 transmitter model controls
  int   busyLeft = 0;
  bit   respOn = 1'b0;
  bit   holdBusy = 1'b0;
  logic prevBusy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: run the transmitter model, advance the reference model
  // on the inputs the DUT samples at this edge, then check the statistics.
  task automatic tick();
    logic ev, pop;
    if (busyLeft == 0 && respOn && txStart && ($urandom_range(0, 2) != 0))
      busyLeft = $urandom_range(1, 6);
    if (holdBusy) txBusy = 1'b1;
    else if (busyLeft > 0) begin txBusy = 1'b1; busyLeft--; end
    else txBusy = 1'b0;
    txDone   = prevBusy && !txBusy;
    prevBusy = txBusy;

    ev  = rxDone && !prevRxM && en && !reset;
    pop = txStart && txBusy && !reset;
    if (reset) begin
      occ = 0; ovM = 1'b0; errM = 0; expQ.delete(); prevRxM = 1'b0; enQM = 1'b0;
    end else begin
      if (ev && rxErr) begin
        if (errM < 255) errM++;
      end else if (ev) begin
        if (occ < DEPTH || pop) begin
          occ++;
          expQ.push_back(rxOut ^ MASK);
        end else ovM = 1'b1;
      end
      if (pop) occ--;
      prevRxM = rxDone;
      enQM    = en;
    end
    @(posedge clk); #1;
    chk("fifoCount", fifoCount, occ);
    chk("overflow", overflow, ovM);
    chk("errCount", errCount, errM);
    chk("rxEn", rxEn, enQM);
    chk("txEn", txEn, enQM);
  endtask

  task automatic pulse(input logic [7:0] b, input logic e);
    rxOut = b; rxErr = e; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    tick();
  endtask

  task automatic waitStart(input int lim);
    int n = 0;
    while (!txStart && n < lim) begin tick(); n++; end
    chk("txStartSeen", txStart, 1'b1);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((expQ.size() != 0 || occ != 0) && n < lim) begin tick(); n++; end
    chk("drainQueue", expQ.size(), 0);
  endtask

  // Monitor: every handshake pops one expected echo; txIn must hold while
  // a request stays pending.
  logic       lastStart = 1'b0;
  logic       lastHs = 1'b0;
  logic [7:0] lastTxIn = 8'd0;
  logic [7:0] monExp;
  initial forever begin
    @(negedge clk);
    if (txStart && lastStart && !lastHs) chk("txInStable", txIn, lastTxIn);
    if (txStart && txBusy && !reset) begin
      if (expQ.size() == 0) begin
        nVec++; nMis++;
        $display("FAIL echoSpurious: got txIn=%0h, expected no transmission", txIn);
      end else begin
        monExp = expQ.pop_front();
        chk("echoByte", txIn, monExp);
      end
      lastHs = 1'b1;
    end else lastHs = 1'b0;
    lastStart = txStart;
    lastTxIn  = txIn;
  end

  initial begin
    reset = 1'b1; en = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxOut = 8'd0;
    txBusy = 1'b0; txDone = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    chk("rstTxStart", txStart, 1'b0);
    chk("rstTxIn", txIn, 8'd0);
    reset = 1'b0; en = 1'b1;
    tick();

    // Single echo with minimum latency
    rxOut = 8'b10001010; rxErr = 1'b0; rxDone = 1'b1;
    tick();
    chk("latTxStartEdgeK", txStart, 1'b0);
    rxDone = 1'b0;
    tick();
    chk("latTxStartEdgeK1", txStart, 1'b1);
    chk("txInFirst", txIn, 8'h75);
    respOn = 1'b1;
    drain(60);
    chk("fifoEmptyAfterEcho", fifoCount, 3'd0);

    // Framing errors and saturation
    respOn = 1'b0;
    pulse(8'hAA, 1'b1);
    chk("errCountOne", errCount, 8'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("noStartOnErr", txStart, 1'b0);
    end
    for (int i = 0; i < 260; i++) pulse(8'($urandom), 1'b1);
    chk("errCountSat", errCount, 8'd255);

    // Overflow with the transmitter held busy
    holdBusy = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) pulse(8'(i), 1'b0);
    chk("ovfCount", fifoCount, 3'd4);
    chk("ovfFlag", overflow, 1'b1);
    holdBusy = 1'b0; respOn = 1'b1;
    drain(120);

    // Busy timeout, retry, then disable while START
    respOn = 1'b0;
    pulse(8'h5C, 1'b0);
    waitStart(20);
    begin
      int n = 0;
      while (txStart && n < 40) begin n++; tick(); end
      chk("timeoutLen", n, TOUT);
    end
    chk("timeoutKeepsByte", fifoCount, 3'd1);
    waitStart(10);
    en = 1'b0;
    tick();
    chk("enAbortStart", txStart, 1'b0);
    chk("enAbortKeepsByte", fifoCount, 3'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("disabledNoStart", txStart, 1'b0);
    end
    en = 1'b1; respOn = 1'b1;
    drain(60);

    // Reset while a frame is in flight and three bytes are queued
    respOn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    pulse(8'h11, 1'b0);
    waitStart(20);
    holdBusy = 1'b1;
    tick();
    chk("popDropsStart", txStart, 1'b0);
    pulse(8'h22, 1'b0); pulse(8'h33, 1'b0); pulse(8'h44, 1'b0);
    chk("queuedThree", fifoCount, 3'd3);
    reset = 1'b1;
    tick();
    chk("midRstTxStart", txStart, 1'b0);
    chk("midRstTxIn", txIn, 8'd0);
    reset = 1'b0; holdBusy = 1'b0; respOn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noStartAfterRst", txStart, 1'b0);
    end

    // Randomized traffic with enable toggling and random busy lengths
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (rxDone) begin
        if ($urandom_range(0, 1) == 0) rxDone = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rxDone = 1'b1;
        rxErr  = ($urandom_range(0, 7) == 0);
        rxOut  = 8'($urandom);
      end else begin
        rxOut = 8'($urandom);
      end
      tick();
    end
    rxDone = 1'b0; en = 1'b1; holdBusy = 1'b0; respOn = 1'b1;
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
